// File: rtl/count_bcd_display.sv
// Binary-to-BCD display stage: a sequential double-dabble converter latches two
// decimal digits, which a free-running refresh divider multiplexes onto a 2-digit display.
module count_bcd_display #(
    parameter int REFRESH_DIV = 50000,
    parameter bit BLANK_LEAD  = 1'b1
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [5:0] value,
    output logic [3:0] bcd_tens,
    output logic [3:0] bcd_ones,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [1:0] an
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    localparam logic [15:0] REF_LAST = 16'(REFRESH_DIV - 1);

    state_t     state_reg, state_next;
    logic [5:0] bin_reg, bin_next;
    logic [5:0] cap_reg, cap_next;
    logic [5:0] cur_val_reg, cur_val_next;
    logic [3:0] tens_reg, tens_next;
    logic [3:0] ones_reg, ones_next;
    logic [3:0] bcd_tens_reg, bcd_tens_next;
    logic [3:0] bcd_ones_reg, bcd_ones_next;
    logic [2:0] bit_cnt_reg, bit_cnt_next;
    logic       busy_reg, busy_next;
    logic       done_reg, done_next;
    logic [3:0] tens_adj, ones_adj;

    logic [15:0] ref_cnt_reg, ref_cnt_next;
    logic        sel_reg, sel_next;      // 0 = ones digit, 1 = tens digit
    logic        ref_wrap;
    logic [1:0]  an_reg, an_next;
    logic [6:0]  seg_reg, seg_next;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 7'b1000000;
            4'd1:    seg_decode = 7'b1111001;
            4'd2:    seg_decode = 7'b0100100;
            4'd3:    seg_decode = 7'b0110000;
            4'd4:    seg_decode = 7'b0011001;
            4'd5:    seg_decode = 7'b0010010;
            4'd6:    seg_decode = 7'b0000010;
            4'd7:    seg_decode = 7'b1111000;
            4'd8:    seg_decode = 7'b0000000;
            4'd9:    seg_decode = 7'b0010000;
            default: seg_decode = 7'b1111111;
        endcase
    endfunction

    // Converter next-state: add-3 correction precedes the shift within one cycle.
    always_comb begin
        state_next    = state_reg;
        bin_next      = bin_reg;
        cap_next      = cap_reg;
        cur_val_next  = cur_val_reg;
        tens_next     = tens_reg;
        ones_next     = ones_reg;
        bcd_tens_next = bcd_tens_reg;
        bcd_ones_next = bcd_ones_reg;
        bit_cnt_next  = bit_cnt_reg;
        done_next     = 1'b0;
        tens_adj      = (tens_reg >= 4'd5) ? tens_reg + 4'd3 : tens_reg;
        ones_adj      = (ones_reg >= 4'd5) ? ones_reg + 4'd3 : ones_reg;

        case (state_reg)
            IDLE: begin
                if (value != cur_val_reg) begin
                    bin_next     = value;
                    cap_next     = value;
                    tens_next    = 4'd0;
                    ones_next    = 4'd0;
                    bit_cnt_next = 3'd0;
                    state_next   = CONV;
                end
            end
            CONV: begin
                {tens_next, ones_next, bin_next} = {tens_adj[2:0], ones_adj, bin_reg, 1'b0};
                bit_cnt_next = bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd5) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bcd_tens_next = tens_reg;
                bcd_ones_next = ones_reg;
                cur_val_next  = cap_reg;
                done_next     = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    // Display path decodes from the latched digits only, never the scratch nibbles.
    always_comb begin
        ref_wrap     = (ref_cnt_reg == REF_LAST);
        ref_cnt_next = ref_wrap ? 16'd0 : ref_cnt_reg + 16'd1;
        sel_next     = sel_reg ^ ref_wrap;
        an_next      = sel_next ? 2'b01 : 2'b10;
        seg_next     = seg_decode(bcd_ones_reg);
        if (sel_next) begin
            if (BLANK_LEAD && (bcd_tens_reg == 4'd0)) begin
                seg_next = 7'b1111111;
            end else begin
                seg_next = seg_decode(bcd_tens_reg);
            end
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            bin_reg      <= 6'd0;
            cap_reg      <= 6'd0;
            cur_val_reg  <= 6'd0;
            tens_reg     <= 4'd0;
            ones_reg     <= 4'd0;
            bcd_tens_reg <= 4'd0;
            bcd_ones_reg <= 4'd0;
            bit_cnt_reg  <= 3'd0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            ref_cnt_reg  <= 16'd0;
            sel_reg      <= 1'b0;
            an_reg       <= 2'b10;
            seg_reg      <= 7'b1000000;
        end else begin
            state_reg    <= state_next;
            bin_reg      <= bin_next;
            cap_reg      <= cap_next;
            cur_val_reg  <= cur_val_next;
            tens_reg     <= tens_next;
            ones_reg     <= ones_next;
            bcd_tens_reg <= bcd_tens_next;
            bcd_ones_reg <= bcd_ones_next;
            bit_cnt_reg  <= bit_cnt_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            ref_cnt_reg  <= ref_cnt_next;
            sel_reg      <= sel_next;
            an_reg       <= an_next;
            seg_reg      <= seg_next;
        end
    end

    assign bcd_tens = bcd_tens_reg;
    assign bcd_ones = bcd_ones_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign seg      = seg_reg;
    assign an       = an_reg;

endmodule
